// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Brief    : Shared types, default constants and the lowest-free-spot search
//            used by the parking allocator.
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int NUM_SPOTS_DEF   = 8;
    localparam int GATE_CYCLES_DEF = 4;

    // Entry-side controller state: waiting for a car, or holding the gate open
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } park_state_e;

    // Index of the lowest zero bit among the first n bits of occ, or n when
    // every one of those bits is set. The wide operand lets a single function
    // serve every legal lot size.
    function automatic int lowest_zero(input logic [63:0] occ, input int n);
        int r;
        r = n;
        for (int i = n - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/park_find_free.sv
`default_nettype none
// ============================================================================
// Module   : park_find_free
// Brief    : Combinational priority search for the lowest-numbered free spot
//            in an occupancy bitmap of NUM_SPOTS bits.
// Revision : 1.0 - initial release
// ============================================================================
module park_find_free
    import parking_pkg::*;
#(
    parameter  int NUM_SPOTS = NUM_SPOTS_DEF,
    localparam int ID_W      = $clog2(NUM_SPOTS)
) (
    input  logic [NUM_SPOTS-1:0] occupancy,
    output logic                 found,
    output logic [ID_W-1:0]      idx
);

    logic [63:0] w_occ_wide;
    int          w_lowest;

    // Zero-extend the bitmap to the search width and locate the first hole
    always_comb begin
        w_occ_wide                  = '0;
        w_occ_wide[NUM_SPOTS-1:0]   = occupancy;
        w_lowest                    = lowest_zero(w_occ_wide, NUM_SPOTS);
    end

    assign found = (w_lowest < NUM_SPOTS);
    assign idx   = found ? ID_W'(w_lowest) : '0;

endmodule
`default_nettype wire

// File: rtl/parking_allocator.sv
`default_nettype none
// ============================================================================
// Module   : parking_allocator
// Brief    : Registered parking-lot controller. Serves entry requests with a
//            req/ack handshake (lowest free spot first), releases spots on exit
//            events, times the entry gate and reports free count / full.
// Revision : 1.0 - initial release
// ============================================================================
module parking_allocator
    import parking_pkg::*;
#(
    parameter  int NUM_SPOTS   = NUM_SPOTS_DEF,
    parameter  int GATE_CYCLES = GATE_CYCLES_DEF,
    localparam int ID_W        = $clog2(NUM_SPOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 entry_req,
    output logic                 entry_ack,
    output logic                 entry_grant,
    output logic [ID_W-1:0]      entry_spot,
    input  logic                 exit_req,
    input  logic [ID_W-1:0]      exit_spot,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic [NUM_SPOTS-1:0] occupancy,
    output logic [ID_W:0]        free_count,
    output logic                 full,
    output logic                 gate_open
);

    // Counter only ever holds GATE_CYCLES-1 down to 0
    localparam int                CNT_W       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  c_gate_init = CNT_W'(GATE_CYCLES - 1);
    localparam logic [ID_W:0]     c_num_spots = (ID_W + 1)'(NUM_SPOTS);

    park_state_e            r_state;
    logic [CNT_W-1:0]       r_gate_cnt;
    logic [NUM_SPOTS-1:0]   r_occupancy;
    logic [ID_W:0]          r_free_count;
    logic                   r_full;
    logic                   r_gate_open;
    logic                   r_entry_ack;
    logic                   r_entry_grant;
    logic [ID_W-1:0]        r_entry_spot;
    logic                   r_exit_ack;
    logic                   r_exit_err;

    park_state_e            w_state_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [NUM_SPOTS-1:0]   w_occ_next;
    logic [ID_W:0]          w_pop_next;
    logic                   w_gate_next;
    logic                   w_entry_ack_next;
    logic                   w_entry_grant_next;
    logic [ID_W-1:0]        w_entry_spot_next;
    logic                   w_exit_valid;
    logic                   w_found;
    logic [ID_W-1:0]        w_free_idx;

    // Search runs on the pre-exit bitmap so a spot freed this cycle is not
    // handed out until the following request.
    park_find_free #(
        .NUM_SPOTS (NUM_SPOTS)
    ) u_find_free (
        .occupancy (r_occupancy),
        .found     (w_found),
        .idx       (w_free_idx)
    );

    // Range check first so an out-of-range index never selects a bitmap bit
    assign w_exit_valid = exit_req
                       && ({1'b0, exit_spot} < c_num_spots)
                       && r_occupancy[exit_spot];

    // Entry FSM, gate timer and combined bitmap update
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_gate_cnt;
        w_occ_next         = r_occupancy;
        w_gate_next        = 1'b0;
        w_entry_ack_next   = 1'b0;
        w_entry_grant_next = 1'b0;
        w_entry_spot_next  = '0;

        case (r_state)
            IDLE: begin
                // The ack cycle itself never re-samples the held request
                if (entry_req && !r_entry_ack) begin
                    w_entry_ack_next = 1'b1;
                    if (w_found) begin
                        w_entry_grant_next     = 1'b1;
                        w_entry_spot_next      = w_free_idx;
                        w_occ_next[w_free_idx] = 1'b1;
                        w_state_next           = GATE;
                        w_gate_next            = 1'b1;
                        w_cnt_next             = c_gate_init;
                    end
                end
            end
            GATE: begin
                if (r_gate_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_gate_next = 1'b1;
                    w_cnt_next  = r_gate_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Allocation only sets zero bits and exit only clears one bits, so
        // the two updates never touch the same index.
        if (w_exit_valid) begin
            w_occ_next[exit_spot] = 1'b0;
        end
    end

    // Popcount of the next bitmap so free_count/full track occupancy exactly
    always_comb begin
        w_pop_next = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            w_pop_next = w_pop_next + (ID_W + 1)'(w_occ_next[i]);
        end
    end

    // State and output registers; reset overrides every pending update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gate_cnt    <= '0;
            r_occupancy   <= '0;
            r_free_count  <= c_num_spots;
            r_full        <= 1'b0;
            r_gate_open   <= 1'b0;
            r_entry_ack   <= 1'b0;
            r_entry_grant <= 1'b0;
            r_entry_spot  <= '0;
            r_exit_ack    <= 1'b0;
            r_exit_err    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_gate_cnt    <= w_cnt_next;
            r_occupancy   <= w_occ_next;
            r_free_count  <= c_num_spots - w_pop_next;
            r_full        <= &w_occ_next;
            r_gate_open   <= w_gate_next;
            r_entry_ack   <= w_entry_ack_next;
            r_entry_grant <= w_entry_grant_next;
            r_entry_spot  <= w_entry_spot_next;
            r_exit_ack    <= exit_req;
            r_exit_err    <= exit_req && !w_exit_valid;
        end
    end

    assign entry_ack   = r_entry_ack;
    assign entry_grant = r_entry_grant;
    assign entry_spot  = r_entry_spot;
    assign exit_ack    = r_exit_ack;
    assign exit_err    = r_exit_err;
    assign occupancy   = r_occupancy;
    assign free_count  = r_free_count;
    assign full        = r_full;
    assign gate_open   = r_gate_open;

endmodule
`default_nettype wire

// File: doc/parking_allocator.md
Name: parking_allocator

Overview:
Sequential, parametrised parking-lot controller, the successor to the combinational entry spot selector. It holds the occupancy bitmap in registers and serves entry requests with a req/ack handshake, granting the lowest-numbered free spot. It accepts exit events that release spots, times the entry gate, and reports free count and full status. It sits between the gate sensors/keypad front end and the display logic.

Parameters:
- NUM_SPOTS, 8, number of parking spots (2..64).
- GATE_CYCLES, 4, clock cycles gate_open stays high after a granted entry (>=1).
- ID_W, $clog2(NUM_SPOTS), spot index width. Derived; never overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- entry_req  in  1  level request from the entry sensor; held until entry_ack
- entry_ack  out  1  one-cycle pulse: request served (granted or denied)
- entry_grant  out  1  valid with entry_ack; 1 = spot allocated, 0 = lot full
- entry_spot  out  ID_W  allocated spot index; valid with entry_ack && entry_grant, else 0
- exit_req  in  1  single-cycle pulse: car leaving
- exit_spot  in  ID_W  spot being released, qualified by exit_req
- exit_ack  out  1  one-cycle pulse, one cycle after exit_req
- exit_err  out  1  valid with exit_ack; 1 = spot out of range or not occupied
- occupancy  out  NUM_SPOTS  registered bitmap; bit i = 1 means spot i is occupied
- free_count  out  ID_W+1  NUM_SPOTS minus popcount(occupancy)
- full  out  1  occupancy all ones
- gate_open  out  1  entry gate drive

Behaviour:
- All outputs are registered. Reset values: occupancy=0, free_count=NUM_SPOTS, full=0, gate_open=0, all ack/grant/err=0, entry_spot=0, FSM=IDLE, gate counter=0.
- Reset during any state wins over everything. On the next edge: gate closes, pending acks are dropped, and the bitmap is cleared.
- FSM states: IDLE, GATE.
- IDLE with entry_req=1 and entry_ack=0 (the ack cycle never re-samples the request):
  - If not full: set the bit of the lowest-index zero in occupancy. Pulse entry_ack=1, entry_grant=1, entry_spot=idx on the next cycle. Enter GATE with gate_open=1 and counter=GATE_CYCLES-1.
  - If full: pulse entry_ack=1 and entry_grant=0 next cycle, stay in IDLE, gate stays closed.
- GATE: gate_open=1. The counter decrements each cycle. At 0, go to IDLE and set gate_open=0. gate_open is high for exactly GATE_CYCLES cycles. entry_req is not serviced in GATE; the requester keeps it asserted and is served after return to IDLE.
- Exit is processed in every FSM state:
  - exit_spot >= NUM_SPOTS, or its bit is 0: exit_ack=1, exit_err=1, no state change.
  - Otherwise: clear the bit, exit_ack=1, exit_err=0.
- Same-cycle entry allocation and valid exit:
  - Allocation uses pre-exit occupancy, so the freed spot is not grantable that cycle.
  - A full lot still denies the entry.
  - Both bitmap updates apply on the same edge.
- free_count and full are derived from the next-state bitmap, so they always match occupancy in the same cycle.
- Entry and exit of the same spot index in one cycle cannot occur, because allocation only picks zero bits and exit only clears one bits.
- Arithmetic: free_count is unsigned ID_W+1 bits and never wraps (range 0..NUM_SPOTS).

Decomposition:
- Package parking_pkg:
  - FSM state enum {IDLE, GATE}.
  - Function for lowest-zero search.
  - Default constants NUM_SPOTS_DEF=8 and GATE_CYCLES_DEF=4.
- Sub-module park_find_free: combinational, parametrised NUM_SPOTS. Inputs: occupancy. Outputs: found (1) and idx (ID_W), the lowest zero bit. It replaces the old fixed 8-bit selector.

Test Plan:
- rst, then entry_req=1 -> entry_ack/entry_grant pulse with entry_spot=0. Then occupancy=0x01, free_count=7, gate_open high exactly 4 cycles.
- Eight sequential entries -> spots 0..7 in order, occupancy=0xFF, full=1, free_count=0. A 9th entry -> entry_ack=1, entry_grant=0, gate_open stays 0.
- From full, exit_req with spot 3 -> exit_ack=1, exit_err=0, occupancy=0xF7, free_count=1. The next entry is granted spot 3.
- occupancy=0x01, exit spot 5 -> exit_ack=1, exit_err=1, occupancy unchanged. With NUM_SPOTS=6, exit spot 7 -> exit_err=1.
- Full lot, entry_req and exit spot 2 in the same cycle -> entry denied, exit ok, occupancy=0xFB. The retried entry (served one cycle after the deny ack) gets spot 2.
- rst asserted mid-GATE after two grants -> next cycle gate_open=0, occupancy=0, free_count=8, FSM in IDLE, no acks.
